// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying one pipeline entry (data bundle + control bundle).
// The producer uses the master modport, the consumer uses the slave modport.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 9
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic MIPS pipeline stage register: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush to a bubble, and a saturating stall-cycle counter.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 9,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_skid_if.slave  up,
   pipe_stage_skid_if.master dn,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKIDF = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [DATA_W-1:0] main_data_r;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic [DATA_W-1:0] skid_data_r;
   logic [CTRL_W-1:0] skid_ctrl_r;
   logic              out_valid_r;
   logic [1:0]        occ_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              in_ready_s;
   logic              in_fire_s;
   logic              load_in_s;
   logic              load_skid_s;
   logic              promote_s;
   logic              clear_main_s;
   logic              clear_skid_s;

   function automatic logic [1:0] occ_of(input state_t s);
      case (s)
         ST_EMPTY: occ_of = 2'd0;
         ST_FULL:  occ_of = 2'd1;
         ST_SKIDF: occ_of = 2'd2;
         default:  occ_of = 2'd0;
      endcase
   endfunction

   // Upstream ready: from registered state with a skid buffer, else pass-through of downstream ready.
   always_comb begin
      if (rst) begin
         in_ready_s = 1'b0;
      end else if (SKID != 0) begin
         in_ready_s = (state_r != ST_SKIDF);
      end else begin
         in_ready_s = !out_valid_r || dn.ready;
      end
   end

   assign in_fire_s = up.valid && in_ready_s;

   // Next-state and register load selection; flush overrides everything.
   always_comb begin
      state_nxt_s  = state_r;
      load_in_s    = 1'b0;
      load_skid_s  = 1'b0;
      promote_s    = 1'b0;
      clear_main_s = 1'b0;
      clear_skid_s = 1'b0;
      if (flush) begin
         state_nxt_s  = ST_EMPTY;
         clear_main_s = 1'b1;
         clear_skid_s = 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  load_in_s   = 1'b1;
                  state_nxt_s = ST_FULL;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_fire_s && dn.ready) begin
                  load_in_s   = 1'b1;
                  state_nxt_s = ST_FULL;
               end else if (!in_fire_s && dn.ready) begin
                  clear_main_s = 1'b1;
                  state_nxt_s  = ST_EMPTY;
               end else if (in_fire_s && (SKID != 0)) begin
                  load_skid_s = 1'b1;
                  state_nxt_s = ST_SKIDF;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_SKIDF: begin
               if (dn.ready) begin
                  promote_s   = 1'b1;
                  state_nxt_s = ST_FULL;
               end else begin
                  state_nxt_s = ST_SKIDF;
               end
            end
            default: begin
               state_nxt_s  = ST_EMPTY;
               clear_main_s = 1'b1;
               clear_skid_s = 1'b1;
            end
         endcase
      end
   end

   // State register plus the status outputs decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         occ_r       <= 2'd0;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         occ_r       <= occ_of(state_nxt_s);
      end
   end

   // Main (head) entry; ctrl is zeroed whenever the stage empties so a bubble carries no control.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data_r <= {DATA_W{1'b0}};
         main_ctrl_r <= {CTRL_W{1'b0}};
      end else if (load_in_s) begin
         main_data_r <= up.data;
         main_ctrl_r <= up.ctrl;
      end else if (promote_s) begin
         main_data_r <= skid_data_r;
         main_ctrl_r <= skid_ctrl_r;
      end else if (clear_main_s) begin
         main_ctrl_r <= {CTRL_W{1'b0}};
      end
   end

   // Skid entry, filled only when the head is stalled and upstream still pushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
      end else if (load_skid_s) begin
         skid_data_r <= up.data;
         skid_ctrl_r <= up.ctrl;
      end else if (clear_skid_s) begin
         skid_ctrl_r <= {CTRL_W{1'b0}};
      end
   end

   // Saturating count of stalled head cycles; survives flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_r && !dn.ready && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
   end

   assign up.ready  = in_ready_s;
   assign dn.valid  = out_valid_r;
   assign dn.data   = main_data_r;
   assign dn.ctrl   = main_ctrl_r;
   assign occupancy = occ_r;
   assign stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1/CNT_W=4 instance and a SKID=0 instance, each
// compared every cycle against a capacity-limited FIFO reference model.
module tb_pipe_stage_skid;
   typedef struct packed {
      logic [31:0] d;
      logic [8:0]  c;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        flush     [2];
   logic        in_valid  [2];
   logic        out_ready [2];
   logic [31:0] in_data   [2];
   logic [8:0]  in_ctrl   [2];
   logic        in_ready_o  [2];
   logic        out_valid_o [2];
   logic [31:0] out_data_o  [2];
   logic [8:0]  out_ctrl_o  [2];
   logic [1:0]  occ_o       [2];
   logic [15:0] st_o        [2];
   logic [3:0]  st0;
   logic [15:0] st1;
   int          vecs;
   int          fails;

   pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(9)) up0 ();
   pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(9)) dn0 ();
   pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(9)) up1 ();
   pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(9)) dn1 ();

   assign up0.valid = in_valid[0];
   assign up0.data  = in_data[0];
   assign up0.ctrl  = in_ctrl[0];
   assign dn0.ready = out_ready[0];
   assign up1.valid = in_valid[1];
   assign up1.data  = in_data[1];
   assign up1.ctrl  = in_ctrl[1];
   assign dn1.ready = out_ready[1];
   assign in_ready_o[0]  = up0.ready;
   assign out_valid_o[0] = dn0.valid;
   assign out_data_o[0]  = dn0.data;
   assign out_ctrl_o[0]  = dn0.ctrl;
   assign in_ready_o[1]  = up1.ready;
   assign out_valid_o[1] = dn1.valid;
   assign out_data_o[1]  = dn1.data;
   assign out_ctrl_o[1]  = dn1.ctrl;
   assign st_o[0] = {12'd0, st0};
   assign st_o[1] = st1;

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(9), .SKID(1), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .flush(flush[0]), .up(up0), .dn(dn0),
      .occupancy(occ_o[0]), .stall_cnt(st0));

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(9), .SKID(0), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .flush(flush[1]), .up(up1), .dn(dn1),
      .occupancy(occ_o[1]), .stall_cnt(st1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", nm, k, act, exp);
      end
   endtask

   // Reference model per instance: a FIFO holding at most 2 (SKID=1) or 1 (SKID=0) entries.
   for (genvar k = 0; k < 2; k++) begin : g_mon
      ent_t q[$];
      int   stall_m;
      int   sz;
      logic exp_rdy;
      always @(negedge clk) begin
         if (rst) begin
            q.delete();
            stall_m = 0;
            chk("rst_in_ready", k, 32'(in_ready_o[k]), 32'd0);
            chk("rst_out_valid", k, 32'(out_valid_o[k]), 32'd0);
            chk("rst_occupancy", k, 32'(occ_o[k]), 32'd0);
            chk("rst_stall_cnt", k, 32'(st_o[k]), 32'd0);
            chk("rst_out_ctrl", k, 32'(out_ctrl_o[k]), 32'd0);
            chk("rst_out_data", k, out_data_o[k], 32'd0);
         end else begin
            sz = q.size();
            exp_rdy = (k == 0) ? (sz < 2) : ((sz == 0) || out_ready[k]);
            chk("in_ready", k, 32'(in_ready_o[k]), 32'(exp_rdy));
            chk("out_valid", k, 32'(out_valid_o[k]), 32'(sz != 0));
            chk("occupancy", k, 32'(occ_o[k]), 32'(sz));
            chk("stall_cnt", k, 32'(st_o[k]), 32'(stall_m));
            if (sz != 0) begin
               chk("out_data", k, out_data_o[k], q[0].d);
               chk("out_ctrl", k, 32'(out_ctrl_o[k]), 32'(q[0].c));
               if (!out_ready[k] && stall_m < ((k == 0) ? 15 : 65535)) stall_m++;
               if (out_ready[k]) void'(q.pop_front());
            end else begin
               chk("bubble_ctrl", k, 32'(out_ctrl_o[k]), 32'd0);
            end
            if (flush[k]) q.delete();
            else if (in_valid[k] && exp_rdy) q.push_back('{d: in_data[k], c: in_ctrl[k]});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_taken(input int k, input int bound);
      bit taken;
      taken = 1'b0;
      for (int i = 0; i < bound && !taken; i++) begin
         @(negedge clk);
         taken = in_ready_o[k];
         @(posedge clk);
         #1;
      end
      vecs++;
      if (!taken) begin
         fails++;
         $display("FAIL wait_taken dut%0d: got no acceptance, expected one within %0d cycles", k, bound);
      end
   endtask

   task automatic check_zero_now();
      for (int k = 0; k < 2; k++) begin
         chk("async_out_valid", k, 32'(out_valid_o[k]), 32'd0);
         chk("async_occupancy", k, 32'(occ_o[k]), 32'd0);
         chk("async_out_ctrl", k, 32'(out_ctrl_o[k]), 32'd0);
         chk("async_out_data", k, out_data_o[k], 32'd0);
         chk("async_stall_cnt", k, 32'(st_o[k]), 32'd0);
         chk("async_in_ready", k, 32'(in_ready_o[k]), 32'd0);
      end
   endtask

   task automatic stream0();
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      in_ctrl[0]   = 9'h1A5;
      for (int i = 1; i <= 8; i++) begin
         in_data[0] = 32'(4 * i);
         step(1);
         in_ctrl[0] = 9'($urandom);
      end
      in_valid[0] = 1'b0;
      step(2);
   endtask

   initial begin
      vecs  = 0;
      fails = 0;
      rst   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         in_data[k] = 32'd0; in_ctrl[k] = 9'd0;
      end
      step(3);
      rst = 1'b0;

      // stream 4, 8, 12, ... through the skid instance
      stream0();

      // backpressure into the skid slot, then drain A, B, C
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1; in_data[0] = 32'h10; in_ctrl[0] = 9'h011;
      step(1);
      in_data[0] = 32'h14; in_ctrl[0] = 9'h022;
      step(1);
      in_data[0] = 32'h18; in_ctrl[0] = 9'h033;
      step(3);
      out_ready[0] = 1'b1;
      wait_taken(0, 8);
      in_valid[0] = 1'b0;
      step(4);

      // flush while full with a pending push of D; only E must follow
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1; in_data[0] = 32'h24; in_ctrl[0] = 9'h0F0;
      step(1);
      in_data[0] = 32'h28; in_ctrl[0] = 9'h00F;
      step(1);
      flush[0] = 1'b1; in_data[0] = 32'h1C; in_ctrl[0] = 9'h1FF;
      step(1);
      flush[0] = 1'b0; in_valid[0] = 1'b0;
      step(1);
      out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 32'h20; in_ctrl[0] = 9'h055;
      step(1);
      in_valid[0] = 1'b0;
      step(3);

      // SKID=0: toggling downstream ready under continuous upstream valid
      in_valid[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         out_ready[1] = ((i % 2) == 0);
         in_data[1] = 32'h100 + 32'(i);
         in_ctrl[1] = 9'($urandom);
         step(1);
      end
      in_valid[1] = 1'b0; out_ready[1] = 1'b1;
      step(2);

      // asynchronous reset in the middle of a cycle while two entries are held
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1; in_data[0] = 32'h30; in_ctrl[0] = 9'h0AA;
      step(1);
      in_data[0] = 32'h34; in_ctrl[0] = 9'h155;
      step(1);
      in_valid[0] = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_zero_now();
      step(1);
      rst = 1'b0;
      stream0();

      // counter saturation, and flush leaves it alone
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1; in_data[0] = 32'h40; in_ctrl[0] = 9'h0C3;
      step(1);
      in_valid[0] = 1'b0;
      step(20);
      chk("stall_sat", 0, 32'(st0), 32'd15);
      flush[0] = 1'b1;
      step(1);
      flush[0] = 1'b0;
      step(1);
      chk("stall_after_flush", 0, 32'(st0), 32'd15);
      out_ready[0] = 1'b1;
      step(1);

      // random traffic on both instances
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            out_ready[k] = ($urandom_range(0, 2) != 0);
            flush[k]     = ($urandom_range(0, 19) == 0);
            in_data[k]   = $urandom;
            in_ctrl[k]   = 9'($urandom);
         end
         step(1);
      end
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b1; flush[k] = 1'b0;
      end
      step(4);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the MIPS pipeline. It generalises the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB flip-flop banks into one block.
- Carries a data bundle plus a control bundle under a valid/ready handshake, with an optional 2-entry skid buffer, synchronous flush and bubble insertion.
- Instances sit between any two stages, so hazard stalls propagate backpressure instead of per-register write enables.

Parameters:
- DATA_W, 32: width of the data bundle (PC, operands, immediates, register indices, concatenated).
- CTRL_W, 9: width of the control bundle (WB 2 + MEM 3 + EX 4). Forced to zero for bubbles.
- SKID, 1: 1 = registered in_ready with 2-entry skid buffer; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch taken / IF_flush).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DATA_W  head data.
- out_ctrl  out  CTRL_W  head control; all zero when out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshake: transfer in when in_valid & in_ready at the rising edge; transfer out when out_valid & out_ready. Order is strictly FIFO; no entry is duplicated or dropped except by flush.
- Storage:
  - main register: drives out_*.
  - skid register: used only when SKID=1.
- States when SKID=1: EMPTY (occ 0), FULL (occ 1), SKIDF (occ 2).
  - EMPTY: in_valid -> main<=in, FULL.
  - FULL, in_valid & out_ready: main<=in, stay FULL.
  - FULL, !in_valid & out_ready: EMPTY.
  - FULL, in_valid & !out_ready: skid<=in, SKIDF.
  - FULL, !in_valid & !out_ready: hold.
  - SKIDF: in_ready=0. out_ready -> main<=skid, FULL; else hold.
  - in_ready = !rst & (state != SKIDF). It depends only on registered state, never on out_ready.
- When SKID=0: states EMPTY/FULL only.
  - in_ready = !rst & (!out_valid | out_ready), combinational.
  - Simultaneous in and out transfer replaces main with no bubble (full throughput).
- out_valid = (state != EMPTY). out_ctrl = main_ctrl when valid, else 0. out_data holds its last value when invalid; the value is don't-care but must not be X after reset.
- Flush has highest priority:
  - Next state is EMPTY; main_ctrl and skid_ctrl are cleared to 0.
  - Any input handshake in the same cycle is discarded.
  - An output handshake in the same cycle still counts downstream; the head was visible.
  - Flush with EMPTY state is a no-op.
- Latency: 1 cycle in-to-out when empty. Full throughput of 1 entry/cycle under continuous out_ready.
- stall_cnt: increments each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1 without wrap, is not cleared by flush, and is cleared only by rst.
- Reset, asynchronous, any time including mid-transfer:
  - state EMPTY; main/skid data and ctrl 0.
  - out_valid 0, out_ctrl 0, out_data 0, occupancy 0, stall_cnt 0, in_ready 0 while rst is high.
  - in_ready rises the cycle rst deasserts. The first entry may be accepted on the first rising edge after deassertion.
- Widths: the block performs no arithmetic on bundles; occupancy is 2 bits; the counter compares against the all-ones value for saturation.

Test Plan:
1. Reset/idle, SKID=1: after rst, in_valid=1, in_data=32'h00000004, in_ctrl=9'h1A5, out_ready=1.
   -> next cycle out_valid=1, out_data=4, out_ctrl=9'h1A5, occupancy=1. Continuous stream 4,8,12,… emerges one per cycle, in order.
2. Backpressure: out_ready=0 while pushing A=32'h10 then B=32'h14.
   -> occupancy 1 then 2, in_ready=0 in SKIDF, C=32'h18 held upstream.
   -> out_ready=1 then drains A, B, C in order with no loss; stall_cnt equals the number of stalled cycles.
3. Flush in SKIDF with in_valid=1, D=32'h1C.
   -> next cycle out_valid=0, out_ctrl=0, occupancy=0. D is not emitted; the next pushed value E=32'h20 appears alone.
4. SKID=0: out_ready toggling 1,0,1,0 with continuous in_valid.
   -> in_ready equals out_ready | !out_valid combinationally each cycle; no entry is duplicated.
5. Asynchronous reset asserted mid-cycle in state SKIDF.
   -> outputs go to 0 immediately without waiting for a clock edge; stall_cnt=0; after release, behaviour matches scenario 1.
6. Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles.
   -> stall_cnt sticks at 15; a flush does not clear it.
